data_memory_responder: RTL and testbench

- Bus-side responder for the core's data memory port.
- Accepts word-aligned bus transactions with per-lane byte enables from the load/store interface.
- Provides word-organised data RAM, a small MMIO window (LEDs, switches, 64-bit cycle counter) and an out-of-range error pulse.
- Returns read data one cycle after the read request.

---
 rtl/data_memory_responder.sv | 98 +++++++++
 tb/tb_data_memory_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: data-bus responder with word RAM, MMIO window (LEDs, switches, 64-bit cycle counter) and miss error pulse
//   clock, reset_n     : rising-edge clock, asynchronous active-low reset
//   bus_address        : byte address, bits [1:0] ignored (word select only)
//   bus_write_data     : lane-aligned write data
//   bus_byte_enable    : per-lane write enables, bit i covers bits [8i+7:8i]
//   bus_read_enable    : read request, data returned on bus_read_data after the next edge
//   bus_write_enable   : write request
//   bus_read_data      : registered read data, held until the next read
//   bus_error          : one-cycle pulse after an access hitting neither RAM nor MMIO
//   leds               : LED register
//   switches           : asynchronous board switches
module data_memory_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int unsigned LED_WIDTH = 16,
    parameter int unsigned SW_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          bus_address,
    input  logic [31:0]          bus_write_data,
    input  logic [3:0]           bus_byte_enable,
    input  logic                 bus_read_enable,
    input  logic                 bus_write_enable,
    output logic [31:0]          bus_read_data,
    output logic                 bus_error,
    output logic [LED_WIDTH-1:0] leds,
    input  logic [SW_WIDTH-1:0]  switches
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]          mem [DEPTH];
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
    logic [63:0]          cnt_q, cnt_d;
    logic [31:0]          shadow_q, shadow_d;
    logic                 ram_hit, mmio_hit;
    logic [1:0]           off;
    logic [AW-1:0]        idx;
    logic [31:0]          wmask, led_word, mmio_rdata;

    always_comb begin
        ram_hit    = bus_address < 32'(4 * DEPTH);
        mmio_hit   = bus_address[31:4] == MMIO_BASE[31:4];
        off        = bus_address[3:2];
        idx        = bus_address[AW+1:2];
        wmask      = {{8{bus_byte_enable[3]}}, {8{bus_byte_enable[2]}},
                      {8{bus_byte_enable[1]}}, {8{bus_byte_enable[0]}}};
        led_word   = 32'(led_q);
        mmio_rdata = off == 2'd0 ? led_word :
                     off == 2'd1 ? 32'(sw_sync_q) :
                     off == 2'd2 ? cnt_q[31:0] : shadow_q;
        // RAM is read combinationally before the edge, so a same-cycle write is not seen
        rdata_d    = !bus_read_enable ? rdata_q :
                     ram_hit ? mem[idx] :
                     mmio_hit ? mmio_rdata : 32'd0;
        err_d      = (bus_read_enable || bus_write_enable) && !ram_hit && !mmio_hit;
        led_d      = (bus_write_enable && mmio_hit && off == 2'd0) ?
                     LED_WIDTH'((led_word & ~wmask) | (bus_write_data & wmask)) : led_q;
        // clear has priority over the free-running increment
        cnt_d      = (bus_write_enable && mmio_hit && off == 2'd2 && |bus_byte_enable) ?
                     64'd0 : cnt_q + 64'd1;
        // reading CNT_LO latches the upper half so a following CNT_HI read is coherent
        shadow_d   = (bus_read_enable && mmio_hit && off == 2'd2) ? cnt_q[63:32] : shadow_q;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++)
            if (bus_write_enable && ram_hit && bus_byte_enable[i])
                mem[idx][8*i +: 8] <= bus_write_data[8*i +: 8];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q   <= '0;
            err_q     <= 1'b0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
        end else begin
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            led_q     <= led_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
        end
    end

    assign bus_read_data = rdata_q;
    assign bus_error     = err_q;
    assign leds          = led_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed vector table, multi-cycle corner sequences and randomized traffic against a transaction-level model
module tb_data_memory_responder;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] MB    = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic [3:0]  bus_byte_enable = '0;
    logic        bus_read_enable = 1'b0;
    logic        bus_write_enable = 1'b0;
    logic [31:0] bus_read_data;
    logic        bus_error;
    logic [15:0] leds;
    logic [15:0] switches = '0;

    always #5 clock = ~clock;

    data_memory_responder #(.DEPTH(DEPTH), .MMIO_BASE(MB), .LED_WIDTH(16), .SW_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .bus_address(bus_address),
        .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
        .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
        .bus_read_data(bus_read_data), .bus_error(bus_error), .leds(leds), .switches(switches)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level reference state
    int          edge_n, cnt_base, rst_edge;
    logic [31:0] ref_mem [DEPTH];
    logic [15:0] ref_led;
    logic [31:0] ref_shadow, ref_rd;
    logic        ref_err;
    logic [15:0] sw_at [int];

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic        we;
        logic [31:0] erd;
        logic        eerr;
        logic [15:0] eled;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // switch value seen by a read at edge e: what was on the pins two edges earlier
    function automatic logic [15:0] sw_seen(input int e);
        return (e - 2 <= rst_edge) ? 16'h0 : sw_at[e - 2];
    endfunction

    task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic re, input logic we);
        logic        ram, mm;
        logic [1:0]  off;
        logic [63:0] cnt;
        bus_address = a; bus_write_data = wd; bus_byte_enable = be;
        bus_read_enable = re; bus_write_enable = we;
        edge_n++;
        sw_at[edge_n] = switches;
        ram = a < 32'(4 * DEPTH);
        mm  = a[31:4] == MB[31:4];
        off = a[3:2];
        cnt = 64'(longint'(edge_n) - longint'(cnt_base) - 1);
        if (re)
            ref_rd = ram ? ref_mem[a[11:2]] :
                     !mm ? 32'h0 :
                     off == 2'd0 ? {16'h0, ref_led} :
                     off == 2'd1 ? {16'h0, sw_seen(edge_n)} :
                     off == 2'd2 ? cnt[31:0] : ref_shadow;
        ref_err = (re || we) && !ram && !mm;
        if (re && mm && off == 2'd2) ref_shadow = cnt[63:32];
        if (we && ram) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], wd, be);
        if (we && mm && off == 2'd0) ref_led = 16'(merge({16'h0, ref_led}, wd, be));
        if (we && mm && off == 2'd2 && |be) cnt_base = edge_n;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        xact(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        ref_rd = '0; ref_err = 1'b0; ref_led = '0; ref_shadow = '0;
        cnt_base = edge_n; rst_edge = edge_n;
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        tbl = '{
            '{32'h10,        32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0,        1'b0, 16'h0},
            '{32'h10,        32'h00AA0000, 4'h4, 1'b0, 1'b1, 32'h0,        1'b0, 16'h0},
            '{32'h10,        32'h0,        4'h0, 1'b1, 1'b0, 32'hDEAABEEF, 1'b0, 16'h0},
            '{32'h20,        32'h0,        4'hF, 1'b0, 1'b1, 32'hDEAABEEF, 1'b0, 16'h0},
            '{32'h20,        32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0,        1'b0, 16'h0},
            '{32'h20,        32'h0,        4'h0, 1'b1, 1'b0, 32'h12345678, 1'b0, 16'h0},
            '{MB,            32'h000000FF, 4'h1, 1'b0, 1'b1, 32'h12345678, 1'b0, 16'h00FF},
            '{MB,            32'h0,        4'h0, 1'b1, 1'b0, 32'h000000FF, 1'b0, 16'h00FF},
            '{MB,            32'hFFFFAB00, 4'h2, 1'b0, 1'b1, 32'h000000FF, 1'b0, 16'hABFF},
            '{MB,            32'h0,        4'h0, 1'b1, 1'b0, 32'h0000ABFF, 1'b0, 16'hABFF},
            '{MB + 32'h4,    32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0000ABFF, 1'b0, 16'hABFF},
            '{32'h10,        32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'h0000ABFF, 1'b0, 16'hABFF},
            '{32'h13,        32'h0,        4'h0, 1'b1, 1'b0, 32'hDEAABEEF, 1'b0, 16'hABFF},
            '{32'hFFC,       32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 32'hDEAABEEF, 1'b0, 16'hABFF},
            '{32'hFFC,       32'h0,        4'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 16'hABFF},
            '{32'h1000,      32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        1'b1, 16'hABFF},
            '{32'h0,         32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 16'hABFF},
            '{32'h2000_0000, 32'h11111111, 4'hF, 1'b0, 1'b1, 32'h0,        1'b1, 16'hABFF},
            '{32'h10,        32'h0,        4'h0, 1'b1, 1'b0, 32'hDEAABEEF, 1'b0, 16'hABFF},
            '{MB + 32'h10,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        1'b1, 16'hABFF}
        };

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check("reset_rd", bus_read_data, 32'h0);
        check("reset_err", bus_error, 1'b0);
        check("reset_leds", leds, 16'h0);

        for (int i = 0; i < 20; i++) begin
            xact(tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].we);
            check($sformatf("vec%0d_rd", i), bus_read_data, tbl[i].erd);
            check($sformatf("vec%0d_err", i), bus_error, tbl[i].eerr);
            check($sformatf("vec%0d_leds", i), leds, tbl[i].eled);
        end

        // switch synchroniser: new value visible to the third read after the change
        switches = 16'hA5A5;
        xact(MB + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        check("sw_edge1", bus_read_data, 32'h0);
        xact(MB + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        check("sw_edge2", bus_read_data, 32'h0);
        xact(MB + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        check("sw_edge3", bus_read_data, 32'h0000A5A5);

        // counter clear, then ten idle cycles
        xact(MB + 32'h8, 32'h0, 4'h1, 1'b0, 1'b1);
        repeat (10) idle();
        xact(MB + 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        check("cnt_after_clear", bus_read_data, 32'd10);

        // near-wrap values
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
        xact(MB + 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        check("cnt_lo_hi_val", bus_read_data, 32'hFFFFFFFE);
        xact(MB + 32'hC, 32'h0, 4'h0, 1'b1, 1'b0);
        check("cnt_hi_shadow", bus_read_data, 32'hFFFFFFFF);
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        idle();
        release dut.cnt_q;
        repeat (3) idle();
        xact(MB + 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        check("cnt_wrap_lo_small", bus_read_data < 32'd8, 1'b1);
        xact(MB + 32'hC, 32'h0, 4'h0, 1'b1, 1'b0);
        check("cnt_wrap_hi", bus_read_data, 32'h0);
        xact(MB + 32'h8, 32'h0, 4'hF, 1'b0, 1'b1);

        // reset asserted while a read is pending
        xact(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        bus_address = 32'h10; bus_read_enable = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_rd", bus_read_data, 32'h0);
        check("midreset_leds", leds, 16'h0);
        check("midreset_err", bus_error, 1'b0);
        @(posedge clock);
        #1;
        check("midreset_rd_edge", bus_read_data, 32'h0);
        check("midreset_err_edge", bus_error, 1'b0);
        @(negedge clock);
        bus_read_enable = 1'b0;
        reset_n = 1'b1;
        model_reset();
        xact(MB + 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        check("post_reset_cnt", bus_read_data, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 65; i++)
            xact((i == 64) ? 32'hFFC : 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            int          k, sel;
            sel = $urandom_range(0, 9);
            k   = $urandom_range(0, 64);
            a   = sel < 5 ? ((k == 64) ? 32'hFFC : 32'(k * 4)) :
                  sel < 8 ? MB + 32'($urandom_range(0, 15)) :
                  sel == 8 ? (32'h1000 | ($urandom & 32'h0FFF_FFFF)) : 32'h0;
            if (sel < 5) a = a + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) switches = 16'($urandom);
            if (sel == 9) idle();
            else xact(a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
            check($sformatf("rand%0d_rd", i), bus_read_data, ref_rd);
            check($sformatf("rand%0d_err", i), bus_error, ref_err);
            check($sformatf("rand%0d_leds", i), leds, ref_led);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
